// File: rtl/acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_pkg : shared Q-format constants and collector state encoding          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package acc_pkg;

  localparam int IW = 24;
  localparam int FW = 8;
  localparam int DW = IW + FW;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    TAIL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/q_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | q_add : W-bit signed adder, wrap-around or saturating at elaboration time |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module q_add
  import acc_pkg::*;
#(
  parameter int W   = DW,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] w_raw;

  assign w_raw = i_a + i_b;
  // Signed overflow: operands agree in sign, result does not.
  assign o_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);

  generate
    if (SAT) begin : g_sat
      assign o_sum = o_ovf ? (i_a[W-1] ? c_MIN : c_MAX) : w_raw;
    end else begin : g_wrap
      assign o_sum = w_raw;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psum_collector : accumulates PE-row partial sums over kernel rows and     |
// | overlap-adds tile edges. Define PSUM_COLLECTOR_SAT_EN for saturating adds |
// | and the sticky sat_flag_o output.                                          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module psum_collector #(
  parameter int IW      = acc_pkg::IW,
  parameter int FW      = acc_pkg::FW,
  parameter int RES_NUM = 9,
  parameter int OUT_NUM = 7,
  parameter int KROWS   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic [RES_NUM*(IW+FW)-1:0]    res_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic                          tile_first_i,
  input  logic                          tile_last_i,
  output logic [OUT_NUM*(IW+FW)-1:0]    out_o,
  output logic [2:0]                    out_cnt_o,
  output logic                          out_last_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i
`ifdef PSUM_COLLECTOR_SAT_EN
  ,
  output logic                          sat_flag_o
`endif
);

  import acc_pkg::state_t;
  import acc_pkg::ACCUM;
  import acc_pkg::EMIT;
  import acc_pkg::TAIL;

  localparam int c_DW = IW + FW;
  localparam int c_CW = (KROWS > 1) ? $clog2(KROWS) : 1;
`ifdef PSUM_COLLECTOR_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_DW-1:0]    r_acc   [RES_NUM];
  logic [c_DW-1:0]    r_carry [2];
  logic [c_CW-1:0]    r_krow_cnt;
  logic               r_tile_last;

  logic [c_DW-1:0]    w_res       [RES_NUM];
  logic [c_DW-1:0]    w_s         [RES_NUM];
  logic [c_DW-1:0]    w_carry_eff [2];
  logic [c_DW-1:0]    w_edge      [2];
  logic [RES_NUM-1:0] w_acc_ovf;
  logic [1:0]         w_edge_ovf;
  logic               w_accept;
  logic               w_row_end;
  logic               w_out_hs;
  logic               w_first_now;

  assign res_ready_o = (r_state == ACCUM);
  assign w_accept    = res_valid_i && res_ready_o;
  assign w_row_end   = w_accept && (r_krow_cnt == c_CW'(KROWS - 1));
  assign w_out_hs    = out_valid_o && out_ready_i;
  assign w_first_now = (r_krow_cnt == '0) && tile_first_i;

  genvar j;
  generate
    for (j = 0; j < RES_NUM; j++) begin : g_acc_lane
      assign w_res[j] = res_i[j*c_DW +: c_DW];
      q_add #(.W(c_DW), .SAT(c_SAT)) u_add (
        .i_a   (r_acc[j]),
        .i_b   (w_res[j]),
        .o_sum (w_s[j]),
        .o_ovf (w_acc_ovf[j])
      );
    end
    // Single-row kernels see tile_first on the same beat that needs the carry.
    for (j = 0; j < 2; j++) begin : g_edge_lane
      assign w_carry_eff[j] = w_first_now ? '0 : r_carry[j];
      q_add #(.W(c_DW), .SAT(c_SAT)) u_add (
        .i_a   (w_s[j]),
        .i_b   (w_carry_eff[j]),
        .o_sum (w_edge[j]),
        .o_ovf (w_edge_ovf[j])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_row_end) w_state_nxt = EMIT;
      EMIT:    if (w_out_hs)  w_state_nxt = r_tile_last ? TAIL : ACCUM;
      TAIL:    if (w_out_hs)  w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else if (clr_i) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RES_NUM; k++) r_acc[k] <= '0;
      r_carry[0]  <= '0;
      r_carry[1]  <= '0;
      r_krow_cnt  <= '0;
      r_tile_last <= 1'b0;
      out_o       <= '0;
      out_cnt_o   <= '0;
      out_last_o  <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (clr_i) begin
      for (int k = 0; k < RES_NUM; k++) r_acc[k] <= '0;
      r_carry[0]  <= '0;
      r_carry[1]  <= '0;
      r_krow_cnt  <= '0;
      r_tile_last <= 1'b0;
      out_o       <= '0;
      out_cnt_o   <= '0;
      out_last_o  <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (w_row_end) begin
        for (int k = 0; k < RES_NUM; k++) r_acc[k] <= '0;
        r_carry[0]  <= w_s[OUT_NUM];
        r_carry[1]  <= w_s[OUT_NUM+1];
        r_krow_cnt  <= '0;
        r_tile_last <= tile_last_i;
        out_o[0*c_DW +: c_DW] <= w_edge[0];
        out_o[1*c_DW +: c_DW] <= w_edge[1];
        for (int i = 2; i < OUT_NUM; i++) out_o[i*c_DW +: c_DW] <= w_s[i];
        out_cnt_o   <= 3'(OUT_NUM);
        out_last_o  <= 1'b0;
        out_valid_o <= 1'b1;
      end else if (w_accept) begin
        for (int k = 0; k < RES_NUM; k++) r_acc[k] <= w_s[k];
        r_krow_cnt <= r_krow_cnt + c_CW'(1);
        if (w_first_now) begin
          r_carry[0] <= '0;
          r_carry[1] <= '0;
        end
      end

      if (r_state == EMIT && w_out_hs) begin
        if (r_tile_last) begin
          out_o                 <= '0;
          out_o[0*c_DW +: c_DW] <= r_carry[0];
          out_o[1*c_DW +: c_DW] <= r_carry[1];
          out_cnt_o             <= 3'd2;
          out_last_o            <= 1'b1;
        end else begin
          out_valid_o <= 1'b0;
        end
      end

      if (r_state == TAIL && w_out_hs) begin
        r_carry[0]  <= '0;
        r_carry[1]  <= '0;
        out_valid_o <= 1'b0;
      end
    end
  end

`ifdef PSUM_COLLECTOR_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_o <= 1'b0;
    end else if (clr_i) begin
      sat_flag_o <= 1'b0;
    end else if ((w_accept && |w_acc_ovf) || (w_row_end && |w_edge_ovf)) begin
      sat_flag_o <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{w_acc_ovf, w_edge_ovf};
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_psum_collector : scoreboard bench with a tile-level reference model    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_psum_collector;

  localparam int DW      = 32;
  localparam int RES_NUM = 9;
  localparam int OUT_NUM = 7;
  localparam int KROWS   = 3;
  localparam int VW      = RES_NUM * DW;
  localparam int TW      = KROWS * VW;

  typedef struct packed {
    logic [OUT_NUM*DW-1:0] data;
    logic [2:0]            cnt;
    logic                  last;
  } beat_t;

  logic                  clk;
  logic                  rst_n;
  logic                  clr_i;
  logic [VW-1:0]         res_i;
  logic                  res_valid_i;
  logic                  res_ready_o;
  logic                  tile_first_i;
  logic                  tile_last_i;
  logic [OUT_NUM*DW-1:0] out_o;
  logic [2:0]            out_cnt_o;
  logic                  out_last_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
`ifdef PSUM_COLLECTOR_SAT_EN
  logic                  sat_flag_o;
`endif

  psum_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr_i),
    .res_i        (res_i),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .tile_first_i (tile_first_i),
    .tile_last_i  (tile_last_i),
    .out_o        (out_o),
    .out_cnt_o    (out_cnt_o),
    .out_last_o   (out_last_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i)
`ifdef PSUM_COLLECTOR_SAT_EN
    ,
    .sat_flag_o   (sat_flag_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;

  // Reference model state: per-tile running sums, edge carry and expected beats
  logic [DW-1:0] m_acc [RES_NUM];
  logic [DW-1:0] m_carry [2];
  int            m_row;
  bit            m_first;
  bit            m_sat;
  beat_t         exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] madd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_COLLECTOR_SAT_EN
    if (s > 64'sd2147483647) begin
      m_sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (s < -64'sd2147483648) begin
      m_sat = 1'b1;
      return 32'h8000_0000;
    end
`endif
    return s[DW-1:0];
  endfunction

  function automatic void model_clear();
    m_row      = 0;
    m_carry[0] = '0;
    m_carry[1] = '0;
    m_sat      = 1'b0;
    exp_q.delete();
  endfunction

  function automatic bit model_beat(input logic [VW-1:0] vec, input bit first, input bit last);
    beat_t b;
    bit    row_end;
    if (m_row == 0) begin
      m_first = first;
      for (int j = 0; j < RES_NUM; j++) m_acc[j] = '0;
    end
    for (int j = 0; j < RES_NUM; j++) m_acc[j] = madd(m_acc[j], vec[j*DW +: DW]);
    row_end = (m_row == KROWS - 1);
    if (row_end) begin
      b.data = '0;
      for (int i = 0; i < OUT_NUM; i++) begin
        logic [DW-1:0] w;
        w = m_acc[i];
        if (i < 2 && !m_first) w = madd(w, m_carry[i]);
        b.data[i*DW +: DW] = w;
      end
      b.cnt  = 3'd7;
      b.last = 1'b0;
      exp_q.push_back(b);
      m_carry[0] = m_acc[7];
      m_carry[1] = m_acc[8];
      if (last) begin
        b.data = '0;
        b.data[0 +: DW]  = m_carry[0];
        b.data[DW +: DW] = m_carry[1];
        b.cnt  = 3'd2;
        b.last = 1'b1;
        exp_q.push_back(b);
        m_carry[0] = '0;
        m_carry[1] = '0;
      end
      m_row = 0;
    end else begin
      m_row++;
    end
    return row_end;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] w);
    logic [VW-1:0] v;
    for (int j = 0; j < RES_NUM; j++) v[j*DW +: DW] = w;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    if ($urandom_range(0, 1) == 0) return $urandom;
    return 32'($urandom_range(0, 4095)) - 32'd2048;
  endfunction

  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected beats on handshakes and checks hold-under-stall
  logic                  p_valid, p_ready, p_last;
  logic [OUT_NUM*DW-1:0] p_out;
  logic [2:0]            p_cnt;
  initial begin
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_last  = 1'b0;
    p_out   = '0;
    p_cnt   = '0;
  end

  always @(negedge clk) begin
    chk("ready_vs_valid", res_ready_o, !out_valid_o);
    if (rst_n && p_valid && !p_ready)
      chk("hold", {out_valid_o, out_o, out_cnt_o, out_last_o}, {1'b1, p_out, p_cnt, p_last});
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {out_o, out_cnt_o, out_last_o}, '0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_beat", {out_o, out_cnt_o, out_last_o}, {e.data, e.cnt, e.last});
      end
    end
    p_valid = out_valid_o;
    p_ready = out_ready_i;
    p_out   = out_o;
    p_cnt   = out_cnt_o;
    p_last  = out_last_o;
  end

  task automatic send_beat(input logic [VW-1:0] vec, input bit first, input bit last);
    bit acc;
    bit row_end;
    int n;
    @(negedge clk);
    res_i        = vec;
    tile_first_i = first;
    tile_last_i  = last;
    res_valid_i  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      acc = res_ready_o;
      @(posedge clk);
      if (!acc) begin
        n++;
        if (n > 500) begin
          $display("FAIL accept_timeout: got no res_ready_o expected accept within 500 cycles");
          $fatal(1);
        end
        @(negedge clk);
      end
    end
    row_end = model_beat(vec, first, last);
    @(negedge clk);
    res_valid_i = 1'b0;
    if (row_end) chk("latency", out_valid_o, 1'b1);
  endtask

  task automatic send_tile(input logic [TW-1:0] t, input bit first, input bit last);
    for (int r = 0; r < KROWS; r++) begin
      bit f, l;
      f = (r == 0) ? first : bit'($urandom_range(0, 1));
      l = (r == KROWS - 1) ? last : bit'($urandom_range(0, 1));
      send_beat(t[r*VW +: VW], f, l);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk(name, {out_o, out_cnt_o, out_last_o, out_valid_o, res_ready_o}, {{(OUT_NUM*DW+5){1'b0}}, 1'b1});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    res_valid_i = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
  endtask

  task automatic apply_clear();
    @(negedge clk);
    clr_i        = 1'b1;
    res_valid_i  = 1'b1;
    res_i        = fill(32'h1234_5678);
    tile_first_i = 1'b1;
    tile_last_i  = 1'b1;
    @(negedge clk);
    clr_i       = 1'b0;
    res_valid_i = 1'b0;
    model_clear();
    check_idle_outputs("clear_outputs");
  endtask

  logic [TW-1:0] t_one;
  logic [TW-1:0] t_neg;
  logic [TW-1:0] t_sat;
  logic [TW-1:0] t_rnd;
  bit            prev_last;

  initial begin
    rst_n        = 1'b0;
    clr_i        = 1'b0;
    res_valid_i  = 1'b0;
    res_i        = '0;
    tile_first_i = 1'b0;
    tile_last_i  = 1'b0;
    model_clear();
    for (int r = 0; r < KROWS; r++) begin
      t_one[r*VW +: VW] = fill(32'h0000_0100);
      t_neg[r*VW +: VW] = '0;
      t_neg[r*VW +: DW] = 32'hFFFF_FF80;
      t_sat[r*VW +: VW] = '0;
    end
    t_sat[0*VW + 3*DW +: DW] = 32'h7FFF_FE00;
    t_sat[1*VW + 3*DW +: DW] = 32'h0000_0100;
    t_sat[2*VW + 3*DW +: DW] = 32'h0000_0100;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;

    // Single tile, first and last
    send_tile(t_one, 1'b1, 1'b1);
    drain();

    // Two tiles sharing an edge
    send_tile(t_one, 1'b1, 1'b0);
    send_tile(t_one, 1'b0, 1'b1);
    drain();

    // Downstream stall while the next beat is pending
    ready_mode = 2;
    send_tile(t_one, 1'b1, 1'b0);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", res_ready_o, 1'b0);
          chk("stall_valid", out_valid_o, 1'b1);
        end
        ready_mode = 0;
      end
    join_none
    send_tile(t_one, 1'b0, 1'b1);
    drain();

    // Negative values
    send_tile(t_neg, 1'b1, 1'b1);
    drain();

    // Reset mid-tile, then clear mid-tile
    send_beat(fill(32'h0000_0100), 1'b1, 1'b0);
    send_beat(fill(32'h0000_0100), 1'b0, 1'b0);
    apply_reset();
    send_tile(t_one, 1'b1, 1'b1);
    drain();
    send_beat(fill(32'h0000_0100), 1'b1, 1'b0);
    send_beat(fill(32'h0000_0100), 1'b0, 1'b0);
    apply_clear();
    send_tile(t_one, 1'b1, 1'b1);
    drain();

    // Lane crossing the positive limit
    send_tile(t_sat, 1'b1, 1'b1);
    drain();
`ifdef PSUM_COLLECTOR_SAT_EN
    chk("sat_flag", sat_flag_o, m_sat);
    apply_clear();
    chk("sat_flag_clr", sat_flag_o, 1'b0);
`endif

    // Randomized tiles with random backpressure
    ready_mode = 1;
    prev_last  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bit f, l;
      for (int r = 0; r < KROWS; r++)
        for (int j = 0; j < RES_NUM; j++)
          t_rnd[r*VW + j*DW +: DW] = rand_word();
      f = prev_last || ($urandom_range(0, 3) == 0);
      l = (k == 39) || ($urandom_range(0, 2) == 0);
      send_tile(t_rnd, f, l);
      prev_last = l;
    end
    drain();
    ready_mode = 0;
`ifdef PSUM_COLLECTOR_SAT_EN
    chk("sat_flag_rand", sat_flag_o, m_sat);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
